eq_i2s_tx: RTL

Output stage directly downstream of Equalizer_8_band. It accepts the signed 16-bit equalized sample stream `y` through a valid/ready handshake and buffers it in a small FIFO. It serializes each sample as a standard I2S frame to the DAC, with the same mono sample on both left and right slots. It generates bclk and lrclk from the system clock and flags underruns.

---
 rtl/eq_pkg.sv | 10 +
 rtl/eq_sample_fifo.sv | 61 ++++++
 rtl/eq_i2s_tx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer datapath and its I2S output stage.
package eq_pkg;

   localparam int unsigned SAMPLE_W  = 16;
   localparam int unsigned NUM_BANDS = 8;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [7:0]          gain_t;

endpackage

// File: rtl/eq_sample_fifo.sv
// Synchronous first-word fall-through sample FIFO with registered occupancy.
// Read data is valid in the same cycle a pop is requested.
module eq_sample_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic [WIDTH-1:0]               wdata,
   input  logic                           pop,
   output logic [WIDTH-1:0]               rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push, do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign level   = level_q;

   // Storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // Occupancy: simultaneous push and pop leave the level unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= '0;
      end else begin
         unique case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/eq_i2s_tx.sv
// I2S transmitter for the equalizer output: buffers samples in a small FIFO and
// sends each one on both left and right slots, MSB first, one bclk after lrclk.
// Define EQ_I2S_TX_HOLD_EN to repeat the last sample on underrun instead of muting.
module eq_i2s_tx
   import eq_pkg::*;
#(
   parameter int unsigned DATA_W     = SAMPLE_W,
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [DATA_W-1:0]                 y_in,
   input  logic                              y_valid,
   output logic                              y_ready,
   output logic                              bclk,
   output logic                              lrclk,
   output logic                              sdata,
   output logic                              underrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

   localparam int unsigned BW = $clog2(2 * DATA_W);
   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned IW = $clog2(DATA_W);

   logic [DW-1:0]     div_q;
   logic              bclk_q, lrclk_q, sdata_q, underrun_q;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] word_q, word_d, hold_word, fifo_rdata;
   logic              fifo_full, fifo_empty;
   logic              div_wrap, tick, frame_start, push, pop, sdata_d;
   logic [IW-1:0]     idx;

   assign div_wrap    = (div_q == DW'(CLK_DIV - 1));
   assign tick        = div_wrap && bclk_q;  // bclk about to fall
   assign bit_d       = (bit_q == BW'(2 * DATA_W - 1)) ? '0 : bit_q + BW'(1);
   assign frame_start = tick && (bit_d == '0);
   assign push        = y_valid && !fifo_full;
   assign pop         = frame_start && !fifo_empty;

   assign y_ready  = !fifo_full;
   assign bclk     = bclk_q;
   assign lrclk    = lrclk_q;
   assign sdata    = sdata_q;
   assign underrun = underrun_q;

   eq_sample_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (y_in),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

`ifdef EQ_I2S_TX_HOLD_EN
   logic [DATA_W-1:0] last_q;

   // Remember the most recent real sample so an underrun can repeat it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   last_q <= '0;
      else if (pop) last_q <= fifo_rdata;
   end

   assign hold_word = last_q;
`else
   assign hold_word = '0;
`endif

   assign word_d = pop ? fifo_rdata : hold_word;

   // Select the bit for the new slot position; b=0 still sends the old right LSB.
   always_comb begin
      idx = '0;
      if (bit_d == '0)                 idx = '0;
      else if (bit_d <= BW'(DATA_W))   idx = IW'(DATA_W - 32'(bit_d));
      else                             idx = IW'(2 * DATA_W - 32'(bit_d));
      sdata_d = word_q[idx];
   end

   // Bit clock divider: bclk toggles every CLK_DIV clk cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         bclk_q <= 1'b0;
      end else if (div_wrap) begin
         div_q  <= '0;
         bclk_q <= ~bclk_q;
      end else begin
         div_q  <= div_q + DW'(1);
      end
   end

   // Slot position, word select, serial data and word load, all on bclk falling ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_q   <= BW'(2 * DATA_W - 1);
         lrclk_q <= 1'b1;
         sdata_q <= 1'b0;
         word_q  <= '0;
      end else if (tick) begin
         bit_q   <= bit_d;
         lrclk_q <= (bit_d >= BW'(DATA_W));
         sdata_q <= sdata_d;
         if (frame_start) word_q <= word_d;
      end
   end

   // One-clk underrun flag when a frame starts with nothing buffered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) underrun_q <= 1'b0;
      else        underrun_q <= frame_start && fifo_empty;
   end

endmodule
